// File: rtl/demux.sv
// Packet-level AXI-Stream demultiplexer: one slave stream fanned out to three buffered master streams.
// Optional per-output packet and drop counters are enabled by defining DEMUX_STATS_EN.

module fallthrough_small_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_BIT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_BIT-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BIT:0]   count;
  logic                 do_wr, do_rd;

  assign do_wr = wr_en && (count != (DEPTH_BIT+1)'(DEPTH));
  assign do_rd = rd_en && !empty;

  // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + DEPTH_BIT'(1);
      if (do_rd) rd_ptr <= rd_ptr + DEPTH_BIT'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (DEPTH_BIT+1)'(1);
        2'b01:   count <= count - (DEPTH_BIT+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry is presented combinationally so a write shows up on the very next cycle.
  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign nearly_full = (count >= (DEPTH_BIT+1)'(DEPTH - 1));
endmodule

module demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 3,
  parameter int SEL_LSB              = 24,
  parameter int SEL_WIDTH            = 2,
  parameter int OUT_FIFO_DEPTH_BIT   = 6
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
  output logic                              m_axis_0_tvalid,
  input  logic                              m_axis_0_tready,
  output logic                              m_axis_0_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
  output logic                              m_axis_1_tvalid,
  input  logic                              m_axis_1_tready,
  output logic                              m_axis_1_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
  output logic                              m_axis_2_tvalid,
  input  logic                              m_axis_2_tready,
  output logic                              m_axis_2_tlast
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]                       pkt_cnt_0,
  output logic [31:0]                       pkt_cnt_1,
  output logic [31:0]                       pkt_cnt_2,
  output logic [31:0]                       drop_cnt
`endif
);
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef struct packed {
    logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata;
    logic [KEEP_W-1:0]               tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser;
    logic                            tlast;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  cur_dst, sel, dst;
  logic                  routed, accept;
  logic [NUM_QUEUES-1:0] wr_en, rd_en, empty, nearly_full, m_tready;
  beat_t                 in_beat;
  beat_t                 out_beat [NUM_QUEUES];

  // The select field is only meaningful on the first beat; later beats follow the latched cur_dst.
  assign sel    = s_axis_tuser[SEL_LSB +: SEL_WIDTH];
  assign dst    = (state == IDLE) ? sel : cur_dst;
  assign routed = (state != DROP) && (int'(dst) < NUM_QUEUES);

  assign s_axis_tready = axis_resetn && (routed ? !nearly_full[dst] : 1'b1);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign in_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep,
                     tuser: s_axis_tuser, tlast: s_axis_tlast};
  assign m_tready = {m_axis_2_tready, m_axis_1_tready, m_axis_0_tready};

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state   <= IDLE;
      cur_dst <= '0;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (!s_axis_tlast) begin
            state   <= routed ? FWD : DROP;
            cur_dst <= sel;
          end
        end
        FWD, DROP: begin
          if (s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NUM_QUEUES; n++) begin : g_out
    logic [BEAT_W-1:0] fifo_dout;

    assign wr_en[n]    = accept && routed && (dst == SEL_WIDTH'(n));
    assign rd_en[n]    = !empty[n] && m_tready[n];
    assign out_beat[n] = beat_t'(fifo_dout);

    fallthrough_small_fifo #(
      .WIDTH     (BEAT_W),
      .DEPTH_BIT (OUT_FIFO_DEPTH_BIT)
    ) u_fifo (
      .clk         (axis_aclk),
      .rst_n       (axis_resetn),
      .din         (in_beat),
      .wr_en       (wr_en[n]),
      .rd_en       (rd_en[n]),
      .dout        (fifo_dout),
      .empty       (empty[n]),
      .nearly_full (nearly_full[n])
    );
  end

  assign m_axis_0_tdata  = out_beat[0].tdata;
  assign m_axis_0_tkeep  = out_beat[0].tkeep;
  assign m_axis_0_tuser  = out_beat[0].tuser;
  assign m_axis_0_tlast  = out_beat[0].tlast;
  assign m_axis_0_tvalid = !empty[0];

  assign m_axis_1_tdata  = out_beat[1].tdata;
  assign m_axis_1_tkeep  = out_beat[1].tkeep;
  assign m_axis_1_tuser  = out_beat[1].tuser;
  assign m_axis_1_tlast  = out_beat[1].tlast;
  assign m_axis_1_tvalid = !empty[1];

  assign m_axis_2_tdata  = out_beat[2].tdata;
  assign m_axis_2_tkeep  = out_beat[2].tkeep;
  assign m_axis_2_tuser  = out_beat[2].tuser;
  assign m_axis_2_tlast  = out_beat[2].tlast;
  assign m_axis_2_tvalid = !empty[2];

`ifdef DEMUX_STATS_EN
  logic [31:0] pkt_cnt [NUM_QUEUES];

  // A packet is counted when its last beat is accepted, whichever way it went.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      for (int n = 0; n < NUM_QUEUES; n++) pkt_cnt[n] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int n = 0; n < NUM_QUEUES; n++) begin
        if (wr_en[n] && s_axis_tlast) pkt_cnt[n] <= pkt_cnt[n] + 32'd1;
      end
      if (accept && !routed && s_axis_tlast) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign pkt_cnt_0 = pkt_cnt[0];
  assign pkt_cnt_1 = pkt_cnt[1];
  assign pkt_cnt_2 = pkt_cnt[2];
`endif
endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed packet scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the three egress streams.

module tb_demux;
  localparam int DW      = 256;
  localparam int KW      = DW / 8;
  localparam int UW      = 128;
  localparam int NQ      = 3;
  localparam int SEL_LSB = 24;
  // An output stops taking beats once it holds 63 of its 64 entries.
  localparam int NF      = 63;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata  [NQ];
  logic [KW-1:0] m_tkeep  [NQ];
  logic [UW-1:0] m_tuser  [NQ];
  logic          m_tvalid [NQ];
  logic          m_tlast  [NQ];
  logic [NQ-1:0] m_tready = '1;
`ifdef DEMUX_STATS_EN
  logic [31:0]   pkt_cnt [NQ];
  logic [31:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  demux dut (
    .axis_aclk       (clk),
    .axis_resetn     (rst_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tuser    (s_tuser),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .m_axis_0_tdata  (m_tdata[0]),
    .m_axis_0_tkeep  (m_tkeep[0]),
    .m_axis_0_tuser  (m_tuser[0]),
    .m_axis_0_tvalid (m_tvalid[0]),
    .m_axis_0_tready (m_tready[0]),
    .m_axis_0_tlast  (m_tlast[0]),
    .m_axis_1_tdata  (m_tdata[1]),
    .m_axis_1_tkeep  (m_tkeep[1]),
    .m_axis_1_tuser  (m_tuser[1]),
    .m_axis_1_tvalid (m_tvalid[1]),
    .m_axis_1_tready (m_tready[1]),
    .m_axis_1_tlast  (m_tlast[1]),
    .m_axis_2_tdata  (m_tdata[2]),
    .m_axis_2_tkeep  (m_tkeep[2]),
    .m_axis_2_tuser  (m_tuser[2]),
    .m_axis_2_tvalid (m_tvalid[2]),
    .m_axis_2_tready (m_tready[2]),
    .m_axis_2_tlast  (m_tlast[2])
`ifdef DEMUX_STATS_EN
    ,
    .pkt_cnt_0       (pkt_cnt[0]),
    .pkt_cnt_1       (pkt_cnt[1]),
    .pkt_cnt_2       (pkt_cnt[2]),
    .drop_cnt        (drop_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one queue of expected beats per output, plus packet-level routing state.
  beat_t q [NQ][$];
  bit    mid_pkt;
  int    pkt_dst;
  int    popped [NQ];
  int    exp_pkt [NQ];
  int    exp_drop;
  bit    last_acc;
  int    acc_total;
  int    cyc;
  int    rel_cyc;
  int    stall_snap;
  bit    rand_rdy;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NQ; n++) begin
      q[n].delete();
      exp_pkt[n] = 0;
    end
    mid_pkt  = 0;
    pkt_dst  = 0;
    exp_drop = 0;
  endtask

  // One clock: compare all outputs at the falling edge, advance the model, return at posedge + 1.
  task automatic step();
    int   d;
    logic er;
    if (rand_rdy) for (int n = 0; n < NQ; n++) m_tready[n] = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    d  = mid_pkt ? pkt_dst : int'(s_tuser[SEL_LSB +: 2]);
    er = 1'b0;
    if (rst_n) er = (d >= NQ) ? 1'b1 : (q[d].size() < NF);
    check("s_tready", s_tready, er);
    for (int n = 0; n < NQ; n++) begin
      check($sformatf("m%0d_tvalid", n), m_tvalid[n], q[n].size() != 0);
      if (q[n].size() != 0)
        check($sformatf("m%0d_beat", n), {m_tdata[n], m_tkeep[n], m_tuser[n], m_tlast[n]}, q[n][0]);
    end
    last_acc = rst_n && s_tvalid && er;
    for (int n = 0; n < NQ; n++) begin
      if (m_tready[n] && q[n].size() != 0) begin
        void'(q[n].pop_front());
        popped[n]++;
      end
    end
    if (last_acc) begin
      acc_total++;
      if (d < NQ) q[d].push_back('{d: s_tdata, k: s_tkeep, u: s_tuser, l: s_tlast});
      if (s_tlast) begin
        mid_pkt = 0;
        if (d < NQ) exp_pkt[d]++;
        else exp_drop++;
      end else begin
        mid_pkt = 1;
        pkt_dst = d;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rel_cyc > 0) begin
      rel_cyc--;
      if (rel_cyc == 0) begin
        stall_snap = acc_total;
        m_tready   = '1;
      end
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Offers the first nsend beats of a len-beat packet; later beats carry select selr.
  task automatic send_pkt(input logic [1:0] sel0, input logic [1:0] selr,
                          input int len, input int nsend, input bit gaps);
    int t;
    for (int b = 0; b < nsend; b++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) idle(1);
      s_tdata = rand_data();
      s_tkeep = KW'($urandom);
      s_tuser = {$urandom, $urandom, $urandom, $urandom};
      s_tuser[SEL_LSB +: 2] = (b == 0) ? sel0 : selr;
      s_tlast  = (b == len - 1);
      s_tvalid = 1'b1;
      t = 0;
      do begin
        step();
        t++;
      end while (!last_acc && t < 500);
      if (!last_acc) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: beat %0d not taken within %0d cycles", b, t);
        s_tvalid = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    int p0, p1, p2, base;
    rand_rdy = 0;
    rel_cyc  = 0;
    for (int n = 0; n < NQ; n++) popped[n] = 0;
    do_reset();

    // Three-beat packet to output 1.
    send_pkt(2'd1, 2'd1, 3, 3, 0);
    idle(4);
    check("t1_out1_beats", popped[1], 3);
    check("t1_out0_beats", popped[0], 0);
    check("t1_out2_beats", popped[2], 0);

    // Select latched on the first beat.
    p0 = popped[0]; p2 = popped[2];
    send_pkt(2'd0, 2'd2, 3, 3, 0);
    idle(4);
    check("t2_out0_beats", popped[0] - p0, 3);
    check("t2_out2_beats", popped[2] - p2, 0);

    // Dropped packet followed by a routed one.
    p0 = popped[0]; p1 = popped[1]; p2 = popped[2];
    send_pkt(2'd3, 2'd3, 4, 4, 0);
    send_pkt(2'd2, 2'd0, 3, 3, 0);
    idle(4);
    check("t3_out2_beats", popped[2] - p2, 3);
    check("t3_out0_beats", popped[0] - p0, 0);
    check("t3_out1_beats", popped[1] - p1, 0);
`ifdef DEMUX_STATS_EN
    check("t3_drop_cnt", drop_cnt, 1);
`endif

    // Stalled output 0 fills to its threshold, then is released.
    base       = acc_total;
    m_tready[0] = 1'b0;
    rel_cyc    = 90;
    send_pkt(2'd0, 2'd0, 70, 70, 0);
    check("t4_accepted_before_release", stall_snap - base, NF);
    p1 = popped[1];
    send_pkt(2'd1, 2'd1, 5, 5, 0);
    idle(80);
    check("t4_out1_beats", popped[1] - p1, 5);

    // Back-to-back single-beat packets from a fresh reset.
    do_reset();
    base = cyc;
    send_pkt(2'd0, 2'd0, 1, 1, 0);
    send_pkt(2'd1, 2'd1, 1, 1, 0);
    send_pkt(2'd2, 2'd2, 1, 1, 0);
    send_pkt(2'd0, 2'd0, 1, 1, 0);
    check("t5_cycles", cyc - base, 4);
    idle(3);
`ifdef DEMUX_STATS_EN
    check("t5_pkt_cnt_0", pkt_cnt[0], 2);
    check("t5_pkt_cnt_1", pkt_cnt[1], 1);
    check("t5_pkt_cnt_2", pkt_cnt[2], 1);
`endif

    // Reset asserted in the middle of a packet.
    m_tready[0] = 1'b0;
    send_pkt(2'd0, 2'd0, 4, 2, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("t6_m0_tvalid_in_reset", m_tvalid[0], 1'b0);
    check("t6_m1_tvalid_in_reset", m_tvalid[1], 1'b0);
    check("t6_m2_tvalid_in_reset", m_tvalid[2], 1'b0);
    check("t6_s_tready_in_reset", s_tready, 1'b0);
    model_reset();
    m_tready = '1;
    repeat (2) step();
    rst_n = 1'b1;
    p1 = popped[1];
    send_pkt(2'd1, 2'd1, 3, 3, 0);
    idle(4);
    check("t6_out1_beats", popped[1] - p1, 3);

    // Randomized traffic with random gaps and random consumer back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 250; i++) begin
      int len;
      len = $urandom_range(1, 8);
      send_pkt(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), len, len, 1);
    end
    rand_rdy = 0;
    m_tready = '1;
    idle(80);
    for (int n = 0; n < NQ; n++)
      check($sformatf("final_m%0d_empty", n), m_tvalid[n], 1'b0);
`ifdef DEMUX_STATS_EN
    for (int n = 0; n < NQ; n++) check($sformatf("final_pkt_cnt_%0d", n), pkt_cnt[n], exp_pkt[n]);
    check("final_drop_cnt", drop_cnt, exp_drop);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
